// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the execute stage: launches mult/multu/div/divu,
// holds the result for a fixed Busy period, then commits it to HI/LO. Also handles mthi/mtlo.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  M_Dop,
  input  logic        MD_start,
  input  logic [1:0]  MD_WE,
  input  logic        req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

  logic        idle, start_ok, we_ok, last_cycle;
  logic [63:0] prod_s, prod_u, result;
  logic        a_neg, b_neg;
  logic [31:0] div_a, div_b, quo_mag, rem_mag, quo, rem;

  assign idle       = (state_q == IDLE);
  assign start_ok   = idle && MD_start && !req;
  assign we_ok      = idle && !MD_start && !req && (MD_WE == 2'd1 || MD_WE == 2'd2);
  assign last_cycle = (cnt_q == CNT_W'(1));

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Divide magnitudes, then fix signs; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
  assign a_neg   = !M_Dop[0] && A[31];
  assign b_neg   = !M_Dop[0] && B[31];
  assign div_a   = a_neg ? -A : A;
  assign div_b   = b_neg ? -B : B;
  assign quo_mag = div_a / div_b;
  assign rem_mag = div_a % div_b;
  assign quo     = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
  assign rem     = a_neg ? -rem_mag : rem_mag;

  always_comb begin
    unique case (M_Dop)
      2'd0:    result = prod_s;
      2'd1:    result = prod_u;
      default: result = (B == 32'd0) ? {hi_q, lo_q} : {rem, quo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok)   state_d = RUN;
      RUN:     if (last_cycle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output defaults to its held value first, so no path through this block infers a latch.
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    if (start_ok) begin
      {hi_tmp_d, lo_tmp_d} = result;
      cnt_d = M_Dop[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (we_ok) begin
      if (MD_WE == 2'd1) hi_d = A;
      else               lo_d = A;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (last_cycle) begin
        hi_d = hi_tmp_q;
        lo_d = lo_tmp_q;
      end
    end
  end

  always_comb begin
    Busy = (state_q == RUN);
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner-case sequences
// and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [1:0]  M_Dop;
  logic        MD_start;
  logic [1:0]  MD_WE;
  logic        req;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[5];

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .M_Dop(M_Dop), .MD_start(MD_start),
    .MD_WE(MD_WE), .req(req), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic on the operand values.
  function automatic void ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo);
    longint          ps, as, bs;
    longint unsigned pu;
    case (op)
      2'd0: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = ps;
      end
      2'd1: begin
        pu = longint'({32'b0, a}) * longint'({32'b0, b});
        {hi, lo} = pu;
      end
      2'd2: if (b != 0) begin
        as = longint'($signed(a));
        bs = longint'($signed(b));
        lo = 32'(as / bs);
        hi = 32'(as % bs);
      end
      default: if (b != 0) begin
        lo = a / b;
        hi = a % b;
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit with_we, input bit req_mid, input string tag);
    logic [31:0] pre_hi, pre_lo;
    int          n;
    pre_hi = m_hi;
    pre_lo = m_lo;
    ref_md(op, a, b, m_hi, m_lo);
    A = a; B = b; M_Dop = op; MD_start = 1'b1; MD_WE = with_we ? 2'd1 : 2'd0;
    tick();
    MD_start = 1'b0; MD_WE = 2'd0;
    A = $urandom; B = $urandom; M_Dop = 2'($urandom);
    n = 0;
    while (Busy && n < 50) begin
      check($sformatf("%s hi_hold", tag), HI, pre_hi);
      check($sformatf("%s lo_hold", tag), LO, pre_lo);
      req = req_mid && (n == 2);
      n++;
      tick();
    end
    req = 1'b0;
    check($sformatf("%s busy_cycles", tag), 32'(n), op[1] ? 32'd10 : 32'd5);
    check($sformatf("%s hi", tag), HI, m_hi);
    check($sformatf("%s lo", tag), LO, m_lo);
  endtask

  task automatic write_hl(input logic [1:0] we, input logic [31:0] a, input logic rq, input string tag);
    MD_WE = we; A = a; req = rq;
    tick();
    MD_WE = 2'd0; req = 1'b0;
    if (!rq && we == 2'd1) m_hi = a;
    if (!rq && we == 2'd2) m_lo = a;
    check($sformatf("%s busy", tag), {31'b0, Busy}, 32'd0);
    check($sformatf("%s hi", tag), HI, m_hi);
    check($sformatf("%s lo", tag), LO, m_lo);
  endtask

  initial begin
    vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_neg1x2"};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, "multu_maxx2"};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"};
    vecs[3] = '{2'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_7_2"};
    vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_m1"};

    reset = 1'b1; A = '0; B = '0; M_Dop = '0; MD_start = 1'b0; MD_WE = '0; req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset busy", {31'b0, Busy}, 32'd0);
    check("reset hi", HI, 32'd0);
    check("reset lo", LO, 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, vecs[i].name);
      check($sformatf("%s table_hi", vecs[i].name), HI, vecs[i].hi);
      check($sformatf("%s table_lo", vecs[i].name), LO, vecs[i].lo);
    end

    write_hl(2'd2, 32'h1234_5678, 1'b0, "mtlo");
    check("mtlo value", LO, 32'h1234_5678);
    run_op(2'd3, 32'h0000_0064, 32'h0, 1'b0, 1'b0, "divu_by0");
    check("divu_by0 lo_kept", LO, 32'h1234_5678);
    check("divu_by0 hi_kept", HI, 32'h0000_0000);
    run_op(2'd2, 32'hFFFF_FF00, 32'h0, 1'b0, 1'b0, "div_by0");

    run_op(2'd0, 32'd7, 32'd9, 1'b1, 1'b0, "start_with_mthi");
    check("start_with_mthi lo63", LO, 32'd63);

    MD_start = 1'b1; M_Dop = 2'd0; A = 32'd3; B = 32'd4; req = 1'b1;
    tick();
    MD_start = 1'b0; req = 1'b0;
    check("req_start busy", {31'b0, Busy}, 32'd0);
    tick();
    check("req_start busy_later", {31'b0, Busy}, 32'd0);
    check("req_start hi", HI, m_hi);
    check("req_start lo", LO, m_lo);

    write_hl(2'd2, 32'hDEAD_BEEF, 1'b1, "req_mtlo");
    write_hl(2'd3, 32'hCAFE_F00D, 1'b0, "we3_ignored");
    write_hl(2'd1, 32'hA5A5_0001, 1'b0, "mthi");

    run_op(2'd1, 32'hDEAD_BEEF, 32'h1234_5679, 1'b0, 1'b1, "req_mid_run");
    run_op(2'd2, 32'h8000_0001, 32'h0000_0003, 1'b0, 1'b1, "req_mid_div");

    for (int i = 0; i < 40; i++) begin
      int unsigned kind;
      logic [31:0] ra, rb;
      kind = $urandom_range(0, 5);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
      if (kind < 4) run_op(2'(kind), ra, rb, 1'($urandom), 1'($urandom),
                           $sformatf("rand%0d_op%0d", i, kind));
      else          write_hl(2'($urandom), ra, 1'($urandom_range(0, 3) == 0),
                             $sformatf("rand%0d_wr", i));
    end

    A = 32'd100; B = 32'd7; M_Dop = 2'd2; MD_start = 1'b1;
    tick();
    MD_start = 1'b0;
    check("rst_mid busy1", {31'b0, Busy}, 32'd1);
    tick();
    tick();
    tick();
    check("rst_mid busy4", {31'b0, Busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid busy", {31'b0, Busy}, 32'd0);
    check("rst_mid hi", HI, 32'd0);
    check("rst_mid lo", LO, 32'd0);
    repeat (15) tick();
    check("rst_mid busy_later", {31'b0, Busy}, 32'd0);
    check("rst_mid no_wb_hi", HI, 32'd0);
    check("rst_mid no_wb_lo", LO, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage HI/LO multiply/divide unit in the P7 pipeline.
- Executes the control decoder's MD_start / M_Dop / MD_WE outputs: mult, multu, div, divu, mthi, mtlo.
- Holds the HI and LO architectural registers and drives Busy to the hazard/stall unit.
- Allows the pipeline to flush MD operations when an exception or interrupt is taken (req).

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, number of Busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  32  forwarded rs value; dividend or multiplicand.
- B  input  32  forwarded rt value; divisor or multiplier.
- M_Dop  input  2  operation select: 0 = mult, 1 = multu, 2 = div, 3 = divu.
- MD_start  input  1  one-cycle pulse that launches the operation selected by M_Dop.
- MD_WE  input  2  direct write: 1 = mthi (HI <= A), 2 = mtlo (LO <= A), 0 or 3 = none.
- req  input  1  exception/interrupt taken this cycle; cancels the E-stage instruction.
- Busy  output  1  an operation is in progress.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (synchronous, active-high): HI = 0, LO = 0, Busy = 0, cycle counter = 0. Any in-flight result is discarded. Reset overrides every other input in the same cycle.
- States:
  - IDLE (Busy = 0).
  - RUN (Busy = 1, counter counts down).
- IDLE -> RUN on a rising edge where MD_start = 1 and req = 0 and Busy = 0:
  - Latch the computed 64-bit result into internal hi_tmp / lo_tmp.
  - Load counter with MULT_CYCLES (M_Dop[1] = 0) or DIV_CYCLES (M_Dop[1] = 1).
  - HI and LO do not change on this edge.
- RUN: the counter decrements each cycle. On the edge where the counter reaches 1, HI <= hi_tmp, LO <= lo_tmp, Busy -> 0.
- Latency: Busy is high for exactly N cycles, starting the cycle after the MD_start cycle. New HI/LO are visible in the first cycle with Busy = 0 after that run.
- Arithmetic:
  - mult: {HI, LO} = signed A * signed B, 64-bit.
  - multu: {HI, LO} = unsigned A * unsigned B, 64-bit.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = unsigned A / B; HI = unsigned A % B.
  - 0x80000000 div 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero (B = 0, div or divu): the full DIV_CYCLES Busy period still runs; HI and LO keep their pre-start values.
- mthi / mtlo:
  - Take effect on the same edge, with no Busy period, when MD_WE = 1 or 2, req = 0, Busy = 0, and MD_start = 0.
  - MD_WE = 3 is ignored.
- Ignored inputs:
  - MD_start or MD_WE while Busy = 1 is ignored; the stall unit guarantees it does not occur.
  - If MD_start and MD_WE are both asserted, MD_start takes priority and MD_WE is ignored.
- req = 1:
  - Suppresses MD_start and MD_WE in that cycle.
  - A run already in progress (Busy = 1) is not cancelled and completes normally, because it belongs to an older committed instruction.
- M_Dop, A and B are sampled only on the start edge. Changes during RUN have no effect.

Test Plan:
- mult, A = 0xFFFFFFFF, B = 0x00000002, one-cycle start pulse -> Busy high for exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. HI/LO are unchanged while Busy = 1.
- multu with the same operands -> HI = 0x00000001, LO = 0xFFFFFFFE after 5 Busy cycles.
- Signed and unsigned division:
  - div, A = 0xFFFFFFF9 (-7), B = 2 -> Busy for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - divu, A = 7, B = 2 -> LO = 3, HI = 1.
  - div, A = 0x80000000, B = 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Divide by zero, mtlo and simultaneous inputs:
  - mtlo A = 0x12345678 -> LO = 0x12345678 on the next edge, Busy stays 0.
  - Then divu with B = 0 -> 10 Busy cycles; LO stays 0x12345678 and HI stays at its prior value.
  - MD_start and MD_WE = 1 asserted in the same cycle -> operation runs and mthi is ignored.
- req:
  - req = 1 together with MD_start (mult 3 * 4) -> Busy stays 0 and HI/LO are unchanged.
  - req = 1 together with MD_WE = 2 -> LO is unchanged.
  - req = 1 during an active run -> the run completes with the correct result.
- Reset mid-run: start div 100 / 7, assert reset at Busy cycle 4 -> next cycle Busy = 0, HI = 0, LO = 0, and no later result write-back occurs.
